// File: rtl/rf_port_arbiter_pkg.sv
// Shared types and constants for the register-file port arbiter.
package rf_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int NREG_DEF = 16;
  localparam int AW_DEF   = 4;

endpackage

// File: rtl/rf_port_arbiter_onehot_dec.sv
// Address-to-one-hot decoder; all-zero when disabled or the address is past NREG-1.
module rf_onehot_dec #(
  parameter int AW   = 4,
  parameter int NREG = 16
) (
  input  logic [AW-1:0]   addr_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  // NOTE: assign a default before the loop so no path through always_comb leaves
  // onehot_o unassigned; otherwise synthesis infers a latch.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en_i && (addr_i == AW'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sequencing read-then-optional-write accesses from two
// requesters onto a shared register file with one-hot Oe0/Oe1/Ld enables.
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            ReqA,
  input  logic            WeA,
  input  logic [AW-1:0]   WaA,
  input  logic [AW-1:0]   Ra0A,
  input  logic [AW-1:0]   Ra1A,
  input  logic            ReqB,
  input  logic            WeB,
  input  logic [AW-1:0]   WaB,
  input  logic [AW-1:0]   Ra0B,
  input  logic [AW-1:0]   Ra1B,
  output logic            GntA,
  output logic            GntB,
  output logic [NREG-1:0] Oe0,
  output logic [NREG-1:0] Oe1,
  output logic [NREG-1:0] Ld,
  output logic            WSel,
  output logic            Busy
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          ptr_q,   ptr_d;
  logic          wsel_q,  wsel_d;
  logic          we_q,    we_d;
  logic [AW-1:0] wa_q,    wa_d;
  logic [AW-1:0] ra0_q,   ra0_d;
  logic [AW-1:0] ra1_q,   ra1_d;

  logic rd_en;
  logic wr_en;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wsel_d  = wsel_q;
    we_d    = we_q;
    wa_d    = wa_q;
    ra0_d   = ra0_q;
    ra1_d   = ra1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ReqA || ReqB) begin
          owner_d = (ReqA && ReqB) ? ptr_q : (ReqB ? REQ_B : REQ_A);
          we_d    = (owner_d == REQ_B) ? WeB  : WeA;
          wa_d    = (owner_d == REQ_B) ? WaB  : WaA;
          ra0_d   = (owner_d == REQ_B) ? Ra0B : Ra0A;
          ra1_d   = (owner_d == REQ_B) ? Ra1B : Ra1A;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        ptr_d = ~owner_q;
        if (we_q) begin
          state_d = ST_WR;
          wsel_d  = owner_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_A;
      ptr_q   <= REQ_A;
      wsel_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      ra0_q   <= '0;
      ra1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wsel_q  <= wsel_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      ra0_q   <= ra0_d;
      ra1_q   <= ra1_d;
    end
  end

  // Rst masks the enables immediately so an access aborted mid-cycle never loads.
  assign rd_en = (state_q == ST_RD) && !Rst;
  assign wr_en = (state_q == ST_WR) && !Rst;

  assign GntA = rd_en && (owner_q == REQ_A);
  assign GntB = rd_en && (owner_q == REQ_B);
  assign Busy = (state_q != ST_IDLE) && !Rst;
  assign WSel = wsel_q;

  rf_onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_oe0 (
    .addr_i   (ra0_q),
    .en_i     (rd_en),
    .onehot_o (Oe0)
  );

  rf_onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_oe1 (
    .addr_i   (ra1_q),
    .en_i     (rd_en),
    .onehot_o (Oe1)
  );

  rf_onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_ld (
    .addr_i   (wa_q),
    .en_i     (wr_en),
    .onehot_o (Ld)
  );

endmodule
